vga_timing_gen: RTL and testbench

//  Free-running VGA raster timing generator: produces the 10-bit horiz_c/vert_c

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_pix_en_div.sv | 26 ++
 rtl/vga_timing_gen.sv | 100 ++++++++++
 tb/tb_vga_timing_gen.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, counter width and FSM state encodings.
package vga_timing_pkg;
  localparam int CW = 10;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_H_ACT = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam int DEF_V_ACT = 480;
  localparam int DEF_V_FP = 10;
  localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;
  localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN = 2'd1;
  localparam state_t S_STOP_PEND = 2'd2;
  function automatic int span(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
endpackage

// File: rtl/vga_pix_en_div.sv
// vga_pix_en_div: free-running divider giving a registered 1-clk pixel strobe every CLK_DIV clocks.
module vga_pix_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] cnt_q, cnt_d;
  logic pix_en_q, pix_en_d;
  always_comb begin
    cnt_d = cnt_q == DW'(CLK_DIV - 1) ? '0 : cnt_q + DW'(1);
    pix_en_d = cnt_d == DW'(CLK_DIV - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pix_en_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pix_en_q <= pix_en_d;
    end
  end
  assign pix_en = pix_en_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster counters with run/stop FSM and zero-latency registered timing outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   H_ACT    = DEF_H_ACT,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   V_ACT    = DEF_V_ACT,
  parameter int   V_FP     = DEF_V_FP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  output logic [CW-1:0] horiz_c,
  output logic [CW-1:0] vert_c,
  output logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);
  localparam int H_TOT = span(H_SYNC, H_BP, H_ACT, H_FP);
  localparam int V_TOT = span(V_SYNC, V_BP, V_ACT, V_FP);
  localparam int H_A0 = H_SYNC + H_BP;
  localparam int H_A1 = H_A0 + H_ACT;
  localparam int V_A0 = V_SYNC + V_BP;
  localparam int V_A1 = V_A0 + V_ACT;
  state_t state_q, state_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic line_q, line_d, frame_q, frame_d, running_q, running_d;
  logic pe, h_last, v_last, stop, adv;
  vga_pix_en_div #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst_n(rst_n), .pix_en(pe));
  // Outputs decode the next count so they line up with the counters they describe.
  always_comb begin
    h_last = h_q == CW'(H_TOT - 1);
    v_last = v_q == CW'(V_TOT - 1);
    stop = !run && pe && h_last && v_last;
    state_d = state_q == S_IDLE ? ((pe && run) ? S_RUN : S_IDLE)
            : run ? S_RUN : stop ? S_IDLE : S_STOP_PEND;
    adv = pe && state_q != S_IDLE;
    h_d = !adv ? h_q : h_last ? '0 : h_q + CW'(1);
    v_d = (!adv || !h_last) ? v_q : v_last ? '0 : v_q + CW'(1);
    running_d = state_d != S_IDLE;
    de_d = running_d && h_d >= CW'(H_A0) && h_d < CW'(H_A1) && v_d >= CW'(V_A0) && v_d < CW'(V_A1);
    hsync_d = (running_d && h_d < CW'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (running_d && v_d < CW'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    pix_x_d = de_d ? h_d - CW'(H_A0) : '0;
    pix_y_d = de_d ? v_d - CW'(V_A0) : '0;
    line_d = pe && running_d && h_d == '0;
    frame_d = line_d && v_d == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q <= '0;
      v_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q <= 1'b0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      line_q <= 1'b0;
      frame_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q <= h_d;
      v_q <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q <= de_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      line_q <= line_d;
      frame_q <= frame_d;
      running_q <= running_d;
    end
  end
  assign horiz_c = h_q;
  assign vert_c = v_q;
  assign pix_en = pe;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de = de_q;
  assign pix_x = pix_x_q;
  assign pix_y = pix_y_q;
  assign line_start = line_q;
  assign frame_start = frame_q;
  assign running = running_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized run/stop stimulus on a shrunken raster, checked against a pixel-index model.
module tb_vga_timing_gen;
  localparam int DIV = 3;
  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 5, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FR = HT * VT;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0;
  logic [9:0] horiz_c, vert_c, pix_x, pix_y, h1, v1, px1, py1;
  logic pix_en, hsync, vsync, de, line_start, frame_start, running;
  logic pe1, hs1, vs1, de1, ls1, fs1, rn1;
  int checks = 0, errors = 0;
  int n = 0, m_p = 0, pe_cnt = 0;
  bit m_on = 0, m_ls = 0, m_fs = 0, cnt_ok = 0;

  vga_timing_gen #(.CLK_DIV(DIV), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF), .SYNC_POL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .horiz_c(horiz_c), .vert_c(vert_c),
    .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x),
    .pix_y(pix_y), .line_start(line_start), .frame_start(frame_start), .running(running));

  vga_timing_gen #(.CLK_DIV(1), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACT(VA), .V_FP(VF), .SYNC_POL(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(1'b1), .horiz_c(h1), .vert_c(v1),
    .pix_en(pe1), .hsync(hs1), .vsync(vs1), .de(de1), .pix_x(px1),
    .pix_y(py1), .line_start(ls1), .frame_start(fs1), .running(rn1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic compare();
    int eh, ev;
    logic e_de, e_pe;
    logic [63:0] e, g;
    eh = m_on ? m_p % HT : 0;
    ev = m_on ? m_p / HT : 0;
    e_de = m_on && eh >= HS + HB && eh < HS + HB + HA && ev >= VS + VB && ev < VS + VB + VA;
    e_pe = n >= 1 && n % DIV == DIV - 1;
    e = {17'd0, 10'(eh), 10'(ev), e_pe, !(m_on && eh < HS), !(m_on && ev < VS), e_de,
         e_de ? 10'(eh - HS - HB) : 10'd0, e_de ? 10'(ev - VS - VB) : 10'd0, m_ls, m_fs, m_on};
    g = {17'd0, horiz_c, vert_c, pix_en, hsync, vsync, de, pix_x, pix_y, line_start, frame_start, running};
    chk("outs", g, e);
  endtask

  task automatic model_reset();
    n = 0;
    m_on = 0;
    m_p = 0;
    m_ls = 0;
    m_fs = 0;
    cnt_ok = 0;
    pe_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    m_ls = 0;
    m_fs = 0;
    if (n >= 2 && n % DIV == 0) begin
      if (!m_on) begin
        if (run) begin
          m_on = 1;
          m_p = 0;
          m_ls = 1;
          m_fs = 1;
        end
      end else if (!run && m_p == FR - 1) begin
        m_on = 0;
        m_p = 0;
        cnt_ok = 0;
      end else begin
        m_p = (m_p + 1) % FR;
        m_ls = m_p % HT == 0;
        m_fs = m_p == 0;
      end
    end
    @(negedge clk);
    compare();
    if (frame_start) begin
      if (cnt_ok) chk("frame_len", 64'(pe_cnt), 64'(FR));
      pe_cnt = 0;
      cnt_ok = 1;
    end
    if (pix_en) pe_cnt++;
    if (n >= 2) chk("div1", {43'd0, pe1, h1, v1}, {43'd0, 1'b1, 10'((n - 2) % HT), 10'(((n - 2) / HT) % VT)});
  endtask

  task automatic wait_p(input int target);
    for (int i = 0; i < 3 * FR * DIV && !(m_on && m_p == target); i++) step();
    chk("reach_h", 64'(horiz_c), 64'(target % HT));
  endtask

  initial begin
    model_reset();
    run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    compare();
    chk("div1_rst", {43'd0, pe1, h1, v1}, 64'd0);
    rst_n = 1'b1;
    repeat (2 * FR * DIV + 40) step();
    wait_p(3 * HT + 5);
    run = 1'b0;
    for (int i = 0; i < 2 * FR * DIV && m_on; i++) step();
    chk("stopped", 64'(running), 64'd0);
    repeat (20) step();
    chk("idle_h", 64'(horiz_c), 64'd0);
    run = 1'b1;
    wait_p(2 * HT + 3);
    run = 1'b0;
    wait_p(6 * HT + 2);
    run = 1'b1;
    wait_p(0);
    chk("resume_run", 64'(running), 64'd1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      step();
    end
    run = 1'b1;
    wait_p(5 * HT + 7);
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare();
    chk("div1_arst", {43'd0, pe1, h1, v1}, 64'd0);
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    repeat (FR * DIV + 60) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
